// File: rtl/gpio_in_reg.sv
// GPIO input register: per-pin synchroniser and debounce filter, edge capture into
// sticky write-1-to-clear status, and a level interrupt derived from that status.
module gpio_in_reg #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gpio_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CW-1:0]    cnt_q  [WIDTH];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] pin_q;
  logic [WIDTH-1:0] rise_en_q;
  logic [WIDTH-1:0] fall_en_q;
  logic [WIDTH-1:0] status_q;
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] set_bits;
  logic [WIDTH-1:0] clr_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++)
      update[i] = (sync_out[i] != pin_q[i]) && (cnt_q[i] == CNT_LAST);
  end

  // Any cycle of agreement with the filtered level restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pin_q <= '0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == pin_q[i]) begin
          cnt_q[i] <= '0;
        end else if (update[i]) begin
          pin_q[i] <= sync_out[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // The new filtered level equals sync_out on an update, so it gives the edge direction.
  assign set_bits = (update & sync_out & rise_en_q) | (update & ~sync_out & fall_en_q);
  assign clr_bits = (we && addr == 2'd3) ? wdata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
    end else begin
      if (we && addr == 2'd1) rise_en_q <= wdata[WIDTH-1:0];
      if (we && addr == 2'd2) fall_en_q <= wdata[WIDTH-1:0];
      status_q <= (status_q & ~clr_bits) | set_bits;
    end
  end

  assign irq = |status_q;

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0:    rdata[WIDTH-1:0] = pin_q;
      2'd1:    rdata[WIDTH-1:0] = rise_en_q;
      2'd2:    rdata[WIDTH-1:0] = fall_en_q;
      default: rdata[WIDTH-1:0] = status_q;
    endcase
  end

endmodule
